// File: rtl/led_rom_sequencer.sv
// Pattern ROM sequencer: fetches 16-bit words, shows the pattern byte on the LEDs
// for the encoded number of prescaled ticks, and handles END, NOP, looping and stop.
module led_rom_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int ADDR_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic [7:0]        o_leds,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_leds;
    logic              r_busy;
    logic              r_done;
    logic [PS_W-1:0]   r_presc;
    logic [7:0]        r_count;

    logic              w_is_end;
    logic              w_is_nop;
    logic              w_tick;
    logic [7:0]        w_dur;

    assign w_is_end = (i_rom_data == 16'h0000);
    assign w_is_nop = (i_rom_data == 16'hFFFF);
    assign w_tick   = (r_presc == PS_MAX);
    // A zero duration still shows the pattern for one tick.
    assign w_dur    = (i_rom_data[7:0] == 8'd0) ? 8'd1 : i_rom_data[7:0];

    // Sequencer state machine; stop behaves exactly like reset.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_leds  <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_presc <= '0;
            r_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (w_is_end) begin
                        if (i_loop_en) begin
                            r_pc <= '0;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else if (w_is_nop) begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end else begin
                        r_leds  <= i_rom_data[15:8];
                        r_count <= w_dur;
                        r_presc <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        if (r_count > 8'd1) begin
                            r_count <= r_count - 8'd1;
                        end else begin
                            r_count <= 8'd0;
                            r_pc    <= r_pc + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_presc <= r_presc + PS_W'(1);
                    end
                end
                S_DONE: begin
                    if (i_start) begin
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pc    <= '0;
                    r_leds  <= 8'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_presc <= '0;
                    r_count <= 8'd0;
                end
            endcase
        end
    end

    assign o_rom_addr = r_pc;
    assign o_leds     = r_leds;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_led_rom_sequencer.sv
// Scoreboard bench for led_rom_sequencer: expectations are queued as each scenario
// is driven and compared against measured LED timing and status outputs.
module tb_led_rom_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  leds;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:255];

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];

    led_rom_sequencer #(.TICK_DIV(4), .ADDR_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_loop_en  (loop_en),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_leds     (leds),
        .o_busy     (busy),
        .o_done     (done)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input int got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic clear_rom(input logic [15:0] fill);
        for (int i = 0; i < 256; i++) rom[i] = fill;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench on the sample just after the edge that captured start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for_leds(input logic [7:0] v, input int lim, output int n);
        n = 1;
        while (leds !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (leds !== v) n = -1;
    endtask

    task automatic hold_len(input logic [7:0] v, input int lim, output int n, output int last_addr);
        n = 0;
        last_addr = -1;
        while (leds === v && n < lim) begin
            n++;
            last_addr = int'(rom_addr);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int la;
        int errs;

        rst = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        clear_rom(16'h0000);

        // Reset values
        sb_push("rst_leds", 0); sb_push("rst_busy", 0);
        sb_push("rst_done", 0); sb_push("rst_addr", 0);
        do_reset();
        sb_pop_check(int'(leds)); sb_pop_check(int'(busy));
        sb_pop_check(int'(done)); sb_pop_check(int'(rom_addr));

        // Basic pattern: latency, hold length, next fetch address
        clear_rom(16'h0000);
        rom[0] = 16'hA010; rom[1] = 16'h1101;
        sb_push("a0_latency", 2); sb_push("a0_hold", 65); sb_push("a0_next_addr", 1);
        sb_push("next_leds", 8'h11);
        pulse_start();
        wait_for_leds(8'hA0, 20, n); sb_pop_check(n);
        hold_len(8'hA0, 200, n, la); sb_pop_check(n); sb_pop_check(la);
        sb_pop_check(int'(leds));

        // NOPs and END without loop
        do_reset();
        clear_rom(16'h0000);
        rom[0] = 16'h5002; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF; rom[3] = 16'h0A01; rom[4] = 16'h0000;
        loop_en = 1'b0;
        sb_push("p50_latency", 2); sb_push("p50_hold_plus_nops", 11); sb_push("p0a_fetch_addr", 3);
        sb_push("p0a_until_done", 5); sb_push("done_flag", 1); sb_push("done_busy", 0);
        sb_push("done_leds", 8'h0A);
        pulse_start();
        wait_for_leds(8'h50, 20, n); sb_pop_check(n);
        hold_len(8'h50, 100, n, la); sb_pop_check(n); sb_pop_check(la);
        n = 0;
        while (!done && n < 50) begin
            n++;
            @(negedge clk);
        end
        sb_pop_check(n);
        repeat (3) @(negedge clk);
        sb_pop_check(int'(done)); sb_pop_check(int'(busy)); sb_pop_check(int'(leds));

        // Restart from DONE
        sb_push("restart_done_clr", 0); sb_push("restart_latency", 2);
        pulse_start();
        sb_pop_check(int'(done));
        wait_for_leds(8'h50, 20, n); sb_pop_check(n);

        // Same program looping
        do_reset();
        loop_en = 1'b1;
        sb_push("loop_p50_latency", 2); sb_push("loop_p50_hold", 11); sb_push("loop_p0a_hold", 6);
        sb_push("loop_back_leds", 8'h50); sb_push("loop_status_errs", 0);
        pulse_start();
        wait_for_leds(8'h50, 20, n); sb_pop_check(n);
        hold_len(8'h50, 100, n, la); sb_pop_check(n);
        hold_len(8'h0A, 100, n, la); sb_pop_check(n);
        sb_pop_check(int'(leds));
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            if (done !== 1'b0 || busy !== 1'b1) errs++;
            @(negedge clk);
        end
        sb_pop_check(errs);
        loop_en = 1'b0;

        // Duration zero behaves as one tick
        do_reset();
        clear_rom(16'h0000);
        rom[0] = 16'h0100; rom[1] = 16'h0201;
        sb_push("dur0_hold", 5); sb_push("dur0_next_addr", 1);
        pulse_start();
        wait_for_leds(8'h01, 20, n);
        hold_len(8'h01, 100, n, la); sb_pop_check(n); sb_pop_check(la);

        // Start during HOLD is ignored
        do_reset();
        clear_rom(16'h0000);
        rom[0] = 16'hA010; rom[1] = 16'h1101;
        sb_push("hold_start_len", 65); sb_push("hold_start_addr", 1);
        pulse_start();
        wait_for_leds(8'hA0, 20, n);
        n = 0;
        while (leds === 8'hA0 && n < 200) begin
            n++;
            la = int'(rom_addr);
            start = (n == 10);
            @(negedge clk);
        end
        start = 1'b0;
        sb_pop_check(n); sb_pop_check(la);

        // Stop mid-HOLD, then restart, then reset mid-HOLD
        do_reset();
        sb_push("stop_leds", 0); sb_push("stop_busy", 0); sb_push("stop_addr", 0);
        sb_push("stop_restart_latency", 2); sb_push("rst_mid_leds", 0); sb_push("rst_mid_busy", 0);
        pulse_start();
        wait_for_leds(8'hA0, 20, n);
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        sb_pop_check(int'(leds)); sb_pop_check(int'(busy)); sb_pop_check(int'(rom_addr));
        pulse_start();
        wait_for_leds(8'hA0, 20, n); sb_pop_check(n);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_pop_check(int'(leds)); sb_pop_check(int'(busy));

        // Stop wins over start in the same cycle
        sb_push("stop_start_busy", 0);
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        sb_pop_check(int'(busy));

        // All-NOP program wraps the address and never leaves busy
        do_reset();
        clear_rom(16'hFFFF);
        sb_push("wrap_reach_ff", 256); sb_push("wrap_addr", 0); sb_push("wrap_busy_errs", 0);
        pulse_start();
        n = 1;
        errs = 0;
        while (rom_addr !== 8'hFF && n < 400) begin
            if (busy !== 1'b1) errs++;
            @(negedge clk);
            n++;
        end
        sb_pop_check(n);
        @(negedge clk);
        sb_pop_check(int'(rom_addr));
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) errs++;
            @(negedge clk);
        end
        sb_pop_check(errs);

        check_val("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_rom_sequencer.md
Name: led_rom_sequencer

Overview:
- Program sequencer for the LED CPU's 256x16 pattern ROM.
- Walks ROM addresses from 0 and drives the fetched pattern byte onto the LEDs.
- Holds each pattern for the duration encoded in the word, then advances.
- Handles end-of-program, NOP, looping, start/stop control and address wrap-around.

Parameters:
- TICK_DIV, 50000, clock cycles per duration tick; legal range ≥1, sim benches use 4.
- ADDR_W, 8, ROM address width; fixed at 8 for the current ROM.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins playback at address 0 when not busy
- stop  in  1  abort playback; takes priority over start
- loop_en  in  1  at END word: 1 = restart at address 0, 0 = finish
- rom_addr  out  ADDR_W  address to ROM; equals pc
- rom_data  in  16  ROM read data, combinational from rom_addr, valid same cycle
- leds  out  8  current pattern
- busy  out  1  high in FETCH or HOLD
- done  out  1  high in DONE state

Behaviour:
- One clock domain; reset is synchronous and active-high; all registers update on the rising edge of clk.
- Word format:
  - [15:8] pattern.
  - [7:0] duration in ticks; duration 0 is treated as 1.
  - 16'h0000 = END.
  - 16'hFFFF = NOP.
- Reset values: state=IDLE, pc=0, leds=0, busy=0, done=0, prescaler=0, tick count=0.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE: start=1 and stop=0 → pc=0, go to FETCH.
- FETCH: one cycle; rom_addr=pc and rom_data is sampled at the end of the cycle.
  - END, loop_en=1 → pc=0, stay in FETCH.
  - END, loop_en=0 → go to DONE; leds keep the last pattern.
  - NOP → pc=pc+1, stay in FETCH; leds unchanged.
  - Any other word → leds=data[15:8], count=max(data[7:0],1), prescaler=0, go to HOLD.
- HOLD:
  - Prescaler counts 0..TICK_DIV-1; a tick fires when prescaler==TICK_DIV-1, then prescaler wraps to 0.
  - On a tick with count>1 → count=count-1.
  - On a tick with count==1 → pc=pc+1, go to FETCH.
- Timing: a pattern stays on leds for exactly dur*TICK_DIV+1 cycles before the next pattern loads. The extra cycle is the FETCH cycle.
- NOP costs 1 cycle. END with loop costs 1 cycle before word 0 is fetched.
- pc wraps 0xFF→0x00 with no error. A program with no END runs forever with busy=1.
- DONE: done=1 and busy=0. start → pc=0, done=0, go to FETCH.
- start while busy: ignored.
- stop=1 in any state, including same cycle as start → IDLE, leds=0, pc=0, done=0, prescaler and count cleared. Effective at the next edge.
- rst mid-playback: same result as the reset values, at the next edge.
- loop_en is sampled only at END.

Test Plan:
- Reset, then start with TICK_DIV=4 and ROM word 0 = 16'hA010:
  - leds=0xA0 appears 2 edges after start.
  - leds holds for 65 cycles; rom_addr=1 during the following FETCH.
- ROM 00:16'h5002, 01:FFFF, 02:FFFF, 03:16'h0A01, 04:0000, loop_en=0:
  - leds sequence 0x50 (9 cycles), then 0x0A.
  - Two NOP cycles occur between the patterns.
  - done=1 after word 4; leds stays 0x0A.
- Same ROM with loop_en=1:
  - After END, leds returns to 0x50 one FETCH cycle later.
  - done never asserts; busy stays 1.
- Duration 0: ROM 16'h0100 → leds=0x01 for TICK_DIV+1 cycles, then pc advances.
- stop asserted mid-HOLD:
  - Next edge: leds=0, busy=0, pc=0.
  - A later start restarts from word 0.
- start asserted during HOLD → no change to pc, count or leds.
- ROM with no END and all NOP: pc wraps 0xFF→0x00 and busy stays 1.
